// File: rtl/cf_bbox_pos_ctrl.sv
// -----------------------------------------------------------------------------
// cf_bbox_pos_ctrl
// Position controller for the CF_bbox overlay stage. Snoops the AXI4-Stream
// video handshake to track beat/line/frame position, arbitrates bbox position
// updates between a host write port and the tracker, and applies accepted
// updates to xStart/yStart only at frame end.
//
// Ports
//   s_axis_video_aclk, rst        clock, async active-high reset
//   VIDEO_tvalid/tready/tuser/tlast  snooped stream handshake + framing
//   host_wr, host_x, host_y       host absolute position write
//   trk_valid/trk_ready, trk_dx/dy tracker signed offset request
//   xStart, yStart                committed bbox position
//   pending, commit, sync_err     status / one-cycle pulses
//   frame_cnt                     completed-frame counter (wraps)
//   drop_cnt, err_cnt             only with CF_BBOX_POS_STATS_EN defined
//
// Optional build macro: CF_BBOX_POS_STATS_EN adds the saturating drop/error
// statistic counters.
//
// state    | meaning
// WAIT_SOF | ignore beats until a tuser beat starts a frame
// ACTIVE   | inside a frame, counting beats and lines
// COMMIT   | one cycle after frame end; apply pending update
// -----------------------------------------------------------------------------
module cf_bbox_pos_ctrl #(
    parameter int NPPC           = 4,
    parameter int POSITION_WIDTH = 12,
    parameter int FRAME_WIDTH    = 3840,
    parameter int FRAME_HEIGHT   = 2160,
    parameter int BOX_W          = 64,
    parameter int BOX_H          = 64,
    parameter int INIT_X         = 10,
    parameter int INIT_Y         = 10
) (
    input  logic                      s_axis_video_aclk,
    input  logic                      rst,
    input  logic                      VIDEO_tvalid,
    input  logic                      VIDEO_tready,
    input  logic                      VIDEO_tuser,
    input  logic                      VIDEO_tlast,
    input  logic                      host_wr,
    input  logic [POSITION_WIDTH-1:0] host_x,
    input  logic [POSITION_WIDTH-1:0] host_y,
    input  logic                      trk_valid,
    output logic                      trk_ready,
    input  logic [POSITION_WIDTH-1:0] trk_dx,
    input  logic [POSITION_WIDTH-1:0] trk_dy,
    output logic [POSITION_WIDTH-1:0] xStart,
    output logic [POSITION_WIDTH-1:0] yStart,
    output logic                      pending,
    output logic                      commit,
    output logic                      sync_err,
    output logic [15:0]               frame_cnt
`ifdef CF_BBOX_POS_STATS_EN
    ,
    output logic [15:0]               drop_cnt,
    output logic [15:0]               err_cnt
`endif
);
    localparam int LINE_BEATS = FRAME_WIDTH / NPPC;
    localparam int BCW        = $clog2(LINE_BEATS + 1);
    localparam int LCW        = $clog2(FRAME_HEIGHT + 1);
    // Two guard bits: one for the sign, one so a large positive offset
    // added to a large position cannot wrap negative.
    localparam int SW         = POSITION_WIDTH + 2;
    localparam logic signed [SW-1:0] MAX_X     = SW'(FRAME_WIDTH - BOX_W);
    localparam logic signed [SW-1:0] MAX_Y     = SW'(FRAME_HEIGHT - BOX_H);
    localparam logic [BCW-1:0]       LAST_BEAT = BCW'(LINE_BEATS - 1);
    localparam logic [LCW-1:0]       LAST_LINE = LCW'(FRAME_HEIGHT - 1);

    typedef enum logic [1:0] {WAIT_SOF, ACTIVE, COMMIT} state_t;

    function automatic logic [POSITION_WIDTH-1:0] clamp_pos(
        input logic signed [SW-1:0] v,
        input logic signed [SW-1:0] hi
    );
        if (v[SW-1])      clamp_pos = '0;
        else if (v > hi)  clamp_pos = hi[POSITION_WIDTH-1:0];
        else              clamp_pos = v[POSITION_WIDTH-1:0];
    endfunction

    state_t                    state_q, state_d;
    logic [BCW-1:0]            beat_cnt_q, beat_cnt_d;
    logic [LCW-1:0]            line_cnt_q, line_cnt_d;
    logic [POSITION_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [POSITION_WIDTH-1:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d;
    logic                      pending_q, pending_d;
    logic                      commit_q, commit_d;
    logic                      sync_err_q, sync_err_d;
    logic                      trk_ready_q, trk_ready_d;
    logic [15:0]               frame_cnt_q, frame_cnt_d;

    logic                      beat, sof_beat, resync, pos_beat;
    logic                      last_beat, line_end, frame_end;
    logic                      trk_acc, do_commit;
    logic [BCW-1:0]            cur_beat;
    logic [LCW-1:0]            cur_line;
    logic signed [SW-1:0]      x_trk, y_trk;

    assign beat     = VIDEO_tvalid & VIDEO_tready;
    // A tuser beat outside ACTIVE starts a frame; the COMMIT cycle accepts it
    // too so a back-to-back SOF right after frame end is not lost.
    assign sof_beat = beat & VIDEO_tuser & (state_q != ACTIVE);
    assign resync   = beat & VIDEO_tuser & (state_q == ACTIVE) &
                      ((beat_cnt_q != '0) | (line_cnt_q != '0));
    assign pos_beat = sof_beat | (beat & (state_q == ACTIVE));
    // beat_cnt_q/line_cnt_q index the next expected beat; SOF and resync
    // beats are forced to position 0/0.
    assign cur_beat  = (sof_beat | resync) ? '0 : beat_cnt_q;
    assign cur_line  = (sof_beat | resync) ? '0 : line_cnt_q;
    assign last_beat = (cur_beat == LAST_BEAT);
    assign line_end  = last_beat | VIDEO_tlast;
    assign frame_end = pos_beat & line_end & (cur_line == LAST_LINE);

    assign trk_acc   = trk_valid & trk_ready_q;
    assign do_commit = (state_q == COMMIT) & pending_q;
    assign x_trk     = $signed({2'b00, x_q}) + $signed({{2{trk_dx[POSITION_WIDTH-1]}}, trk_dx});
    assign y_trk     = $signed({2'b00, y_q}) + $signed({{2{trk_dy[POSITION_WIDTH-1]}}, trk_dy});

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        line_cnt_d  = line_cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        sh_x_d      = sh_x_q;
        sh_y_d      = sh_y_q;
        pending_d   = pending_q;
        commit_d    = 1'b0;
        sync_err_d  = 1'b0;
        frame_cnt_d = frame_cnt_q;

        if (state_q == COMMIT) begin
            state_d     = WAIT_SOF;
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (pending_q) begin
                x_d       = sh_x_q;
                y_d       = sh_y_q;
                commit_d  = 1'b1;
                pending_d = 1'b0;
            end
        end

        if (pos_beat) begin
            sync_err_d = resync | (VIDEO_tlast & ~last_beat) | (last_beat & ~VIDEO_tlast);
            state_d    = frame_end ? COMMIT : ACTIVE;
            if (line_end) begin
                beat_cnt_d = '0;
                line_cnt_d = (cur_line == LAST_LINE) ? '0 : cur_line + 1'b1;
            end else begin
                beat_cnt_d = cur_beat + 1'b1;
                line_cnt_d = cur_line;
            end
        end

        // Host wins; a simultaneous tracker accept is consumed and dropped.
        if (host_wr) begin
            sh_x_d    = clamp_pos($signed({2'b00, host_x}), MAX_X);
            sh_y_d    = clamp_pos($signed({2'b00, host_y}), MAX_Y);
            pending_d = 1'b1;
        end else if (trk_acc) begin
            sh_x_d    = clamp_pos(x_trk, MAX_X);
            sh_y_d    = clamp_pos(y_trk, MAX_Y);
            pending_d = 1'b1;
        end

        trk_ready_d = ~pending_d;
    end

    always_ff @(posedge s_axis_video_aclk or posedge rst) begin
        if (rst) begin
            state_q     <= WAIT_SOF;
            beat_cnt_q  <= '0;
            line_cnt_q  <= '0;
            x_q         <= POSITION_WIDTH'(INIT_X);
            y_q         <= POSITION_WIDTH'(INIT_Y);
            sh_x_q      <= POSITION_WIDTH'(INIT_X);
            sh_y_q      <= POSITION_WIDTH'(INIT_Y);
            pending_q   <= 1'b0;
            commit_q    <= 1'b0;
            sync_err_q  <= 1'b0;
            trk_ready_q <= 1'b1;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            line_cnt_q  <= line_cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            sh_x_q      <= sh_x_d;
            sh_y_q      <= sh_y_d;
            pending_q   <= pending_d;
            commit_q    <= commit_d;
            sync_err_q  <= sync_err_d;
            trk_ready_q <= trk_ready_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign xStart    = x_q;
    assign yStart    = y_q;
    assign pending   = pending_q;
    assign commit    = commit_q;
    assign sync_err  = sync_err_q;
    assign trk_ready = trk_ready_q;
    assign frame_cnt = frame_cnt_q;

`ifdef CF_BBOX_POS_STATS_EN
    logic        pend_trk_q, pend_trk_d;
    logic        drop_ev;
    logic [15:0] drop_q, errc_q;

    always_comb begin
        pend_trk_d = pend_trk_q;
        if (do_commit) pend_trk_d = 1'b0;
        if (host_wr)   pend_trk_d = 1'b0;
        else if (trk_acc) pend_trk_d = 1'b1;
    end

    // A tracker value about to commit this cycle is not overwritten.
    assign drop_ev = host_wr & (trk_acc | (pending_q & pend_trk_q & ~do_commit));

    always_ff @(posedge s_axis_video_aclk or posedge rst) begin
        if (rst) begin
            pend_trk_q <= 1'b0;
            drop_q     <= '0;
            errc_q     <= '0;
        end else begin
            pend_trk_q <= pend_trk_d;
            if (drop_ev && drop_q != 16'hFFFF)    drop_q <= drop_q + 16'd1;
            if (sync_err_d && errc_q != 16'hFFFF) errc_q <= errc_q + 16'd1;
        end
    end

    assign drop_cnt = drop_q;
    assign err_cnt  = errc_q;
`endif

endmodule

// File: tb/tb_cf_bbox_pos_ctrl.sv
// Testbench for cf_bbox_pos_ctrl, run with a reduced frame size so whole
// frames fit in a short simulation. Expected values come from a plain
// arithmetic model of positions, pending state and event counts.
module tb_cf_bbox_pos_ctrl;
    localparam int PW   = 12;
    localparam int NP   = 4;
    localparam int FW   = 64;
    localparam int FH   = 32;
    localparam int BXW  = 16;
    localparam int BXH  = 8;
    localparam int LB   = FW / NP;
    localparam int MAXX = FW - BXW;
    localparam int MAXY = FH - BXH;

    logic clk = 0, rst = 1;
    logic tvalid = 0, tready = 0, tuser = 0, tlast = 0;
    logic host_wr = 0, trk_valid = 0, trk_ready;
    logic [PW-1:0] host_x = '0, host_y = '0, trk_dx = '0, trk_dy = '0;
    logic [PW-1:0] xs, ys;
    logic pending, commit, sync_err;
    logic [15:0] frame_cnt;
`ifdef CF_BBOX_POS_STATS_EN
    logic [15:0] drop_cnt, err_cnt;
`endif

    cf_bbox_pos_ctrl #(.NPPC(NP), .POSITION_WIDTH(PW), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH),
                       .BOX_W(BXW), .BOX_H(BXH), .INIT_X(10), .INIT_Y(10)) dut (
        .s_axis_video_aclk(clk), .rst(rst),
        .VIDEO_tvalid(tvalid), .VIDEO_tready(tready), .VIDEO_tuser(tuser), .VIDEO_tlast(tlast),
        .host_wr(host_wr), .host_x(host_x), .host_y(host_y),
        .trk_valid(trk_valid), .trk_ready(trk_ready), .trk_dx(trk_dx), .trk_dy(trk_dy),
        .xStart(xs), .yStart(ys), .pending(pending), .commit(commit), .sync_err(sync_err),
        .frame_cnt(frame_cnt)
`ifdef CF_BBOX_POS_STATS_EN
        , .drop_cnt(drop_cnt), .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // reference model
    int exp_x, exp_y, sh_x, sh_y, exp_frames, exp_commits, exp_errs, exp_drops, exp_errc;
    bit exp_pend, pend_trk;
    int n_commit = 0, n_err = 0;
    int n_cmp = 0, n_bad = 0;
    bit gaps = 0;

    always @(negedge clk) begin
        if (commit === 1'b1)   n_commit++;
        if (sync_err === 1'b1) n_err++;
    end

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        exp_x = 10; exp_y = 10; sh_x = 10; sh_y = 10;
        exp_pend = 0; pend_trk = 0; exp_frames = 0; exp_drops = 0; exp_errc = 0;
    endtask

    task automatic model_frame_end();
        exp_frames++;
        if (exp_pend) begin
            exp_x = sh_x; exp_y = sh_y; exp_pend = 0; pend_trk = 0; exp_commits++;
        end
    endtask

    task automatic add_err(input int n);
        exp_errs += n; exp_errc += n;
    endtask

    task automatic send_beat(input bit u, input bit l);
        int tries = 0;
        bit done = 0;
        tuser = u; tlast = l;
        while (!done) begin
            tvalid = gaps ? ($urandom_range(5) != 0) : 1'b1;
            tready = gaps ? ($urandom_range(4) != 0) : 1'b1;
            @(posedge clk);
            done = tvalid & tready;
            #1;
            tries++;
            if (tries > 200) begin
                $display("FAIL beat_timeout: got no handshake want handshake");
                $fatal(1);
            end
        end
        tvalid = 0; tuser = 0; tlast = 0;
    endtask

    task automatic send_line(input int n, input bit u, input bit l);
        for (int i = 0; i < n; i++) send_beat(u && i == 0, l && i == n - 1);
    endtask

    task automatic send_lines(input int from, input int to);
        for (int ln = from; ln <= to; ln++) send_line(LB, ln == 0, 1'b1);
    endtask

    task automatic do_host(input int x, input int y);
        host_wr = 1; host_x = PW'(x); host_y = PW'(y);
        @(posedge clk); #1 host_wr = 0;
        if (exp_pend && pend_trk) exp_drops++;
        sh_x = clampi(x, MAXX); sh_y = clampi(y, MAXY); exp_pend = 1; pend_trk = 0;
    endtask

    task automatic do_trk(input int dx, input int dy);
        trk_valid = 1; trk_dx = PW'(dx); trk_dy = PW'(dy);
        @(negedge clk);
        n_cmp++;
        if (trk_ready !== !exp_pend) begin
            n_bad++; $display("FAIL trk_ready: got %0b want %0b", trk_ready, !exp_pend);
        end
        @(posedge clk); #1 trk_valid = 0;
        if (!exp_pend) begin
            sh_x = clampi(exp_x + dx, MAXX); sh_y = clampi(exp_y + dy, MAXY);
            exp_pend = 1; pend_trk = 1;
        end
    endtask

    task automatic do_both(input int hx, input int hy, input int dx, input int dy);
        host_wr = 1; host_x = PW'(hx); host_y = PW'(hy);
        trk_valid = 1; trk_dx = PW'(dx); trk_dy = PW'(dy);
        @(negedge clk);
        n_cmp++;
        if (trk_ready !== !exp_pend) begin
            n_bad++; $display("FAIL both_trk_ready: got %0b want %0b", trk_ready, !exp_pend);
        end
        @(posedge clk); #1 host_wr = 0; trk_valid = 0;
        if (!exp_pend || pend_trk) exp_drops++;
        sh_x = clampi(hx, MAXX); sh_y = clampi(hy, MAXY); exp_pend = 1; pend_trk = 0;
    endtask

    task automatic test_reset();
        rst = 1; model_reset(); exp_commits = 0; exp_errs = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (xs !== 12'd10 || ys !== 12'd10 || pending !== 0 || commit !== 0 || sync_err !== 0 ||
            frame_cnt !== 16'd0 || trk_ready !== 1) begin
            n_bad++;
            $display("FAIL reset_state: got x=%0d y=%0d p=%0b c=%0b e=%0b f=%0d r=%0b want x=10 y=10 p=0 c=0 e=0 f=0 r=1",
                     xs, ys, pending, commit, sync_err, frame_cnt, trk_ready);
        end
        @(posedge clk); #1 rst = 0;
    endtask

    task automatic test_clean();
        gaps = 0;
        send_line(5, 1'b0, 1'b1);
        repeat (2) begin send_lines(0, FH - 1); model_frame_end(); end
        repeat (2) @(negedge clk); #1;
        n_cmp++;
        if (frame_cnt !== 16'(exp_frames) || xs !== 12'd10 || ys !== 12'd10) begin
            n_bad++; $display("FAIL clean_frames: got f=%0d x=%0d y=%0d want f=%0d x=10 y=10", frame_cnt, xs, ys, exp_frames);
        end
        n_cmp++;
        if (n_commit !== 0 || n_err !== 0) begin
            n_bad++; $display("FAIL clean_pulses: got commits=%0d errs=%0d want 0 0", n_commit, n_err);
        end
    endtask

    task automatic test_host();
        gaps = 1;
        send_lines(0, 9);
        do_host(100, 200);
        @(negedge clk);
        n_cmp++;
        if (pending !== 1 || xs !== 12'd10) begin
            n_bad++; $display("FAIL host_pending: got p=%0b x=%0d want p=1 x=10", pending, xs);
        end
        send_lines(10, FH - 2);
        send_line(LB - 1, 1'b0, 1'b0);
        send_beat(1'b0, 1'b1);
        model_frame_end();
        @(negedge clk);
        n_cmp++;
        if (commit !== 0 || xs !== 12'd10) begin
            n_bad++; $display("FAIL host_commit_early: got c=%0b x=%0d want c=0 x=10", commit, xs);
        end
        @(negedge clk);
        n_cmp++;
        if (commit !== 1 || xs !== 12'(exp_x) || ys !== 12'(exp_y) || pending !== 0) begin
            n_bad++; $display("FAIL host_commit: got c=%0b x=%0d y=%0d p=%0b want c=1 x=%0d y=%0d p=0",
                              commit, xs, ys, pending, exp_x, exp_y);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (n_commit !== exp_commits) begin
            n_bad++; $display("FAIL host_pulse_len: got %0d want %0d", n_commit, exp_commits);
        end
    endtask

    task automatic test_tracker();
        gaps = 1;
        send_lines(0, 3); do_host(10, 10); send_lines(4, FH - 1); model_frame_end();
        send_lines(0, 5);
        do_trk(-20, 5);
        send_lines(6, 8);
        do_trk(3, 3);
        send_lines(9, FH - 1); model_frame_end();
        repeat (2) @(negedge clk); #1;
        n_cmp++;
        if (xs !== 12'd0 || ys !== 12'd15 || xs !== 12'(exp_x) || ys !== 12'(exp_y)) begin
            n_bad++; $display("FAIL trk_commit: got x=%0d y=%0d want x=0 y=15", xs, ys);
        end
        n_cmp++;
        if (trk_ready !== 1 || n_commit !== exp_commits) begin
            n_bad++; $display("FAIL trk_after: got r=%0b commits=%0d want r=1 commits=%0d", trk_ready, n_commit, exp_commits);
        end
    endtask

    task automatic test_clamp();
        gaps = 1;
        send_lines(0, 2); do_host(4000, 2150); send_lines(3, FH - 1); model_frame_end();
        repeat (2) @(negedge clk); #1;
        n_cmp++;
        if (xs !== 12'(MAXX) || ys !== 12'(MAXY)) begin
            n_bad++; $display("FAIL clamp_host: got x=%0d y=%0d want x=%0d y=%0d", xs, ys, MAXX, MAXY);
        end
        send_lines(0, 2); do_trk(30, 30); send_lines(3, FH - 1); model_frame_end();
        repeat (2) @(negedge clk); #1;
        n_cmp++;
        if (xs !== 12'(MAXX) || ys !== 12'(MAXY) || n_commit !== exp_commits) begin
            n_bad++; $display("FAIL clamp_trk: got x=%0d y=%0d commits=%0d want x=%0d y=%0d commits=%0d",
                              xs, ys, n_commit, MAXX, MAXY, exp_commits);
        end
    endtask

    task automatic test_both();
        gaps = 1;
        send_lines(0, 4); do_both(50, 60, 8, 8); send_lines(5, FH - 1); model_frame_end();
        repeat (2) @(negedge clk); #1;
        n_cmp++;
        if (xs !== 12'(exp_x) || ys !== 12'(exp_y) || xs !== 12'(clampi(50, MAXX))) begin
            n_bad++; $display("FAIL both_value: got x=%0d y=%0d want x=%0d y=%0d", xs, ys, exp_x, exp_y);
        end
`ifdef CF_BBOX_POS_STATS_EN
        n_cmp++;
        if (drop_cnt !== 16'(exp_drops)) begin
            n_bad++; $display("FAIL both_drop: got %0d want %0d", drop_cnt, exp_drops);
        end
`endif
    endtask

    task automatic test_commit_edge();
        gaps = 1;
        send_lines(0, 2); do_host(20, 4); send_lines(3, FH - 1); model_frame_end();
        do_host(30, 6);
        @(negedge clk);
        n_cmp++;
        if (commit !== 1 || xs !== 12'd20 || ys !== 12'd4 || pending !== 1) begin
            n_bad++; $display("FAIL edge_commit: got c=%0b x=%0d y=%0d p=%0b want c=1 x=20 y=4 p=1", commit, xs, ys, pending);
        end
        send_lines(0, FH - 1); model_frame_end();
        repeat (2) @(negedge clk); #1;
        n_cmp++;
        if (xs !== 12'(exp_x) || ys !== 12'(exp_y) || pending !== 0) begin
            n_bad++; $display("FAIL edge_next: got x=%0d y=%0d p=%0b want x=%0d y=%0d p=0", xs, ys, pending, exp_x, exp_y);
        end
    endtask

    task automatic test_sync();
        gaps = 1;
        send_lines(0, 1); do_host(40, 16); send_lines(2, 2);
        send_line(11, 1'b0, 1'b1);
        send_lines(4, 6);
        send_beat(1'b1, 1'b0);
        add_err(2);
        repeat (2) @(negedge clk); #1;
        n_cmp++;
        if (n_err !== exp_errs || n_commit !== exp_commits || pending !== 1 || frame_cnt !== 16'(exp_frames)) begin
            n_bad++; $display("FAIL sync_resync: got errs=%0d commits=%0d p=%0b f=%0d want errs=%0d commits=%0d p=1 f=%0d",
                              n_err, n_commit, pending, frame_cnt, exp_errs, exp_commits, exp_frames);
        end
        send_line(LB - 1, 1'b0, 1'b1);
        send_lines(1, 4);
        send_line(LB, 1'b0, 1'b0);
        add_err(1);
        send_lines(6, FH - 1); model_frame_end();
        repeat (2) @(negedge clk); #1;
        n_cmp++;
        if (n_err !== exp_errs || n_commit !== exp_commits || xs !== 12'(exp_x) || ys !== 12'(exp_y)) begin
            n_bad++; $display("FAIL sync_recover: got errs=%0d commits=%0d x=%0d y=%0d want %0d %0d %0d %0d",
                              n_err, n_commit, xs, ys, exp_errs, exp_commits, exp_x, exp_y);
        end
`ifdef CF_BBOX_POS_STATS_EN
        n_cmp++;
        if (err_cnt !== 16'(exp_errc)) begin
            n_bad++; $display("FAIL sync_errcnt: got %0d want %0d", err_cnt, exp_errc);
        end
`endif
    endtask

    task automatic test_random();
        gaps = 1;
        for (int f = 0; f < 6; f++) begin
            int act = $urandom_range(4);
            int r = $urandom_range(FH - 3, 1);
            send_lines(0, r);
            case (act)
                1: do_host($urandom_range(4095), $urandom_range(4095));
                2: do_trk(int'($urandom_range(60)) - 30, int'($urandom_range(60)) - 30);
                3: do_both($urandom_range(4095), $urandom_range(4095), 5, -5);
                4: begin
                    do_trk(int'($urandom_range(60)) - 30, int'($urandom_range(60)) - 30);
                    do_host($urandom_range(80), $urandom_range(40));
                end
                default: ;
            endcase
            send_lines(r + 1, FH - 1); model_frame_end();
            repeat (2) @(negedge clk); #1;
            n_cmp++;
            if (xs !== 12'(exp_x) || ys !== 12'(exp_y) || pending !== exp_pend || trk_ready !== !exp_pend ||
                frame_cnt !== 16'(exp_frames) || n_commit !== exp_commits || n_err !== exp_errs) begin
                n_bad++;
                $display("FAIL random_frame%0d: got x=%0d y=%0d p=%0b f=%0d c=%0d e=%0d want x=%0d y=%0d p=%0b f=%0d c=%0d e=%0d",
                         f, xs, ys, pending, frame_cnt, n_commit, n_err, exp_x, exp_y, exp_pend, exp_frames, exp_commits, exp_errs);
            end
`ifdef CF_BBOX_POS_STATS_EN
            n_cmp++;
            if (drop_cnt !== 16'(exp_drops)) begin
                n_bad++; $display("FAIL random_drop%0d: got %0d want %0d", f, drop_cnt, exp_drops);
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        gaps = 1;
        send_lines(0, 3); do_host(33, 3); send_lines(4, 9);
        rst = 1; model_reset();
        @(negedge clk);
        n_cmp++;
        if (xs !== 12'd10 || ys !== 12'd10 || pending !== 0 || frame_cnt !== 16'd0 || trk_ready !== 1) begin
            n_bad++; $display("FAIL midrst_state: got x=%0d y=%0d p=%0b f=%0d r=%0b want 10 10 0 0 1",
                              xs, ys, pending, frame_cnt, trk_ready);
        end
        @(posedge clk); #1 rst = 0;
        send_lines(10, 12);
        send_lines(0, FH - 1); model_frame_end();
        repeat (2) @(negedge clk); #1;
        n_cmp++;
        if (frame_cnt !== 16'(exp_frames) || xs !== 12'd10 || n_commit !== exp_commits || n_err !== exp_errs) begin
            n_bad++; $display("FAIL midrst_frame: got f=%0d x=%0d c=%0d e=%0d want f=%0d x=10 c=%0d e=%0d",
                              frame_cnt, xs, n_commit, n_err, exp_frames, exp_commits, exp_errs);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_host();
        test_tracker();
        test_clamp();
        test_both();
        test_commit_edge();
        test_sync();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
